// File: rtl/crc16_t_if.sv
// rtl/crc16_t_if.sv - link-layer and PHY byte-stream signals of crc16_t
interface crc16_t_if;
  logic       tx_data_on;
  logic       tx_sop_en;
  logic       tx_eop_en;
  logic       tx_lt_sop;
  logic       tx_lt_eop;
  logic       tx_lt_valid;
  logic       tx_lt_ready;
  logic [7:0] tx_lt_data;
  logic       tx_sop;
  logic       tx_eop;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;

  modport master (
    output tx_data_on, tx_lt_sop, tx_lt_eop, tx_lt_valid, tx_lt_data, tx_ready,
    input  tx_sop_en, tx_eop_en, tx_lt_ready, tx_sop, tx_eop, tx_valid, tx_data
  );

  modport slave (
    input  tx_data_on, tx_lt_sop, tx_lt_eop, tx_lt_valid, tx_lt_data, tx_ready,
    output tx_sop_en, tx_eop_en, tx_lt_ready, tx_sop, tx_eop, tx_valid, tx_data
  );
endinterface

// File: rtl/crc16_t.sv
// rtl/crc16_t.sv - DATA packet transmitter appending CRC-16/USB after the payload
module crc16_usb_byte (
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);
  logic [15:0] c;

  // Reflected CRC-16: data bits enter LSB first.
  always_comb begin
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ 16'hA001;
      else                c = c >> 1;
    end
    crc_out = c;
  end
endmodule

module crc16_t (
  input  logic      clk,
  input  logic      rst_n,
  crc16_t_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, DATA, CRC_LO, CRC_HI} state_t;

  state_t      state;
  logic [15:0] crc;
  logic [15:0] crc_next;
  logic        phy_xfer;
  logic        out_free;
  logic        lt_xfer;

  crc16_usb_byte u_crc (
    .crc_in  (crc),
    .data    (bus.tx_lt_data),
    .crc_out (crc_next)
  );

  // A disabled block counts no PHY transfer, so the output register stays busy.
  assign phy_xfer        = bus.tx_data_on && bus.tx_valid && bus.tx_ready;
  assign out_free        = !bus.tx_valid || phy_xfer;
  assign bus.tx_lt_ready = rst_n && bus.tx_data_on && out_free &&
                           (state == IDLE || state == DATA);
  assign lt_xfer         = bus.tx_lt_valid && bus.tx_lt_ready;
  assign bus.tx_sop_en   = lt_xfer && (state == IDLE) && bus.tx_lt_sop;
  assign bus.tx_eop_en   = phy_xfer && bus.tx_eop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      crc          <= 16'hFFFF;
      bus.tx_valid <= 1'b0;
      bus.tx_sop   <= 1'b0;
      bus.tx_eop   <= 1'b0;
      bus.tx_data  <= 8'h00;
    end else if (bus.tx_data_on) begin
      if (phy_xfer) bus.tx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (lt_xfer && bus.tx_lt_sop) begin
            bus.tx_valid <= 1'b1;
            bus.tx_sop   <= 1'b1;
            bus.tx_eop   <= 1'b0;
            bus.tx_data  <= bus.tx_lt_data;
            crc          <= 16'hFFFF;
            state        <= bus.tx_lt_eop ? CRC_LO : DATA;
          end
        end
        DATA: begin
          if (lt_xfer) begin
            bus.tx_valid <= 1'b1;
            bus.tx_sop   <= 1'b0;
            bus.tx_eop   <= 1'b0;
            bus.tx_data  <= bus.tx_lt_data;
            crc          <= crc_next;
            if (bus.tx_lt_eop) state <= CRC_LO;
          end
        end
        CRC_LO: begin
          if (out_free) begin
            bus.tx_valid <= 1'b1;
            bus.tx_sop   <= 1'b0;
            bus.tx_eop   <= 1'b0;
            bus.tx_data  <= ~crc[7:0];
            state        <= CRC_HI;
          end
        end
        CRC_HI: begin
          if (out_free) begin
            bus.tx_valid <= 1'b1;
            bus.tx_sop   <= 1'b0;
            bus.tx_eop   <= 1'b1;
            bus.tx_data  <= ~crc[15:8];
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/crc16_t.md
CRC16_T -- requirements
Module: crc16_t

Interface
REQ-001 The block SHALL have these ports, one per line:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- tx_data_on  in  1  enable from link_control; when low, the block is frozen
- tx_sop_en  out  1  pulse to link_control: DATA PID byte accepted
- tx_eop_en  out  1  pulse to link_control: final CRC byte handed to PHY
- tx_lt_sop  in  1  link layer: first byte (PID) of DATA packet
- tx_lt_eop  in  1  link layer: last byte (PID or payload) of DATA packet
- tx_lt_valid  in  1  link layer byte valid
- tx_lt_ready  out  1  block accepts link-layer byte
- tx_lt_data  in  8  link layer byte
- tx_sop  out  1  PHY: current byte is PID
- tx_eop  out  1  PHY: current byte is CRC high byte (last)
- tx_valid  out  1  PHY byte valid
- tx_ready  in  1  PHY accepts byte
- tx_data  out  8  PHY byte

Function
REQ-002 A link-layer transfer SHALL occur on a cycle where tx_lt_valid && tx_lt_ready; a PHY transfer SHALL occur on a cycle where tx_valid && tx_ready.
REQ-003 The block SHALL have a single output register (tx_data/tx_sop/tx_eop/tx_valid), and the output register SHALL be free when tx_valid==0 or a PHY transfer occurs this cycle.
REQ-004 The FSM states SHALL be IDLE, DATA, CRC_LO, CRC_HI.
REQ-005 tx_lt_ready SHALL equal tx_data_on && (state==IDLE || state==DATA) && output register free (combinational).
REQ-006 In IDLE, an accepted byte with tx_lt_sop==1 SHALL:
- load the output register with tx_sop=1, tx_eop=0;
- set CRC to 16'hFFFF;
- pulse tx_sop_en for one cycle (the acceptance cycle, combinational);
- move to DATA, or to CRC_LO if tx_lt_eop==1 (zero-length packet).
REQ-007 In IDLE, an accepted byte with tx_lt_sop==0 SHALL be discarded; state, CRC and the output register are unchanged.
REQ-008 In DATA, an accepted byte SHALL:
- load the output register with tx_sop=0, tx_eop=0;
- update the CRC;
- move to CRC_LO if tx_lt_eop==1.
- A tx_lt_sop asserted in DATA SHALL be ignored.
REQ-009 The CRC update SHALL be CRC-16/USB, processing data bits LSB first, bit i=0..7: fb=crc[0]^d[i]; crc=crc>>1; if fb, crc^=16'hA001. The PID byte is excluded from the CRC.
REQ-010 In CRC_LO, when the output register is free, the block SHALL load tx_data=~crc[7:0], tx_sop=0, tx_eop=0 and go to CRC_HI.
REQ-011 In CRC_HI, when the output register is free, the block SHALL load tx_data=~crc[15:8], tx_eop=1 and go to IDLE.
REQ-012 tx_eop_en SHALL pulse for one cycle (combinational) on the PHY transfer of the byte with tx_eop==1.
REQ-013 Latency SHALL be one cycle: a byte accepted at edge N appears with tx_valid=1 after edge N; with tx_ready held high, throughput is one byte per cycle, and the two CRC bytes follow the last payload byte back-to-back.
REQ-014 While tx_valid==1 and tx_ready==0, tx_data, tx_sop and tx_eop SHALL hold stable.
REQ-015 If a PHY transfer occurs and no new byte is loaded in the same cycle, tx_valid SHALL clear at the next edge.
REQ-016 While tx_data_on==0, the block SHALL be frozen:
- tx_lt_ready=0, tx_sop_en=0, tx_eop_en=0;
- FSM, CRC and the output register hold;
- tx_valid remains asserted if it was set, but no PHY transfer is counted (tx_eop_en stays 0).

Reset
REQ-017 On rst_n low, the block SHALL asynchronously set state=IDLE, crc=16'hFFFF, tx_valid=0, tx_sop=0, tx_eop=0, tx_data=8'h00; tx_lt_ready, tx_sop_en and tx_eop_en are then 0.
REQ-018 Reset asserted mid-packet SHALL abandon the packet; after release, the block SHALL wait in IDLE for a new tx_lt_sop.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Standard payload: PID 8'hC3 then payload 31..39 (ASCII "123456789"), eop on 8'h39, tx_ready=1 -> PHY sequence C3(sop),31..39,C8,B4(eop); tx_eop_en pulses once.
- Zero-length packet: PID 8'h4B with sop+eop -> PHY 4B(sop),00,00(eop).
- Backpressure: as the standard payload, with tx_ready low for 3 cycles on byte 8'h35 -> tx_data holds 35, tx_lt_ready=0 during the stall, final CRC still C8,B4.
- Stray byte: byte 8'hAA with tx_lt_sop=0 in IDLE -> accepted, no PHY output, tx_sop_en stays 0.
- Enable gating: tx_data_on dropped for 4 cycles mid-payload -> no transfers, outputs held, packet completes with correct CRC after re-enable.
- Reset mid-packet: rst_n pulsed after 3 payload bytes -> tx_valid=0 immediately; next packet "123456789" yields C8,B4.
